mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between the fetch requester and the load/store requester.
- Only one memory transaction is in flight at a time.
- Drives the memory port and asserts a stall that the core uses to gate its functional clock.
- Sits between IF/ID and the memory model, replacing their direct memory connections.

---
 rtl/scc_mem_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 57 +++++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scc_mem_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding,
// requester ids and default bus widths.
package scc_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Requester ids stored in the winner latch
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

endpackage : scc_mem_pkg

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requesters, plus the
// starvation counter that eventually forces a waiting fetch through.
module mem_arb_pick
    import scc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic idle_i,
    input  logic if_req_i,
    input  logic halt_i,
    input  logic d_req_i,
    output logic fire_o,
    output logic winner_o
);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       if_elig;
    logic       starved;

    // Eligibility and winner: data by default, fetch once it has been starved
    always_comb begin
        if_elig  = if_req_i & ~halt_i;
        starved  = (starve_cnt_q == 4'(STARVE_LIMIT));
        fire_o   = idle_i & (d_req_i | if_elig);
        winner_o = REQ_IF;
        if (d_req_i && !(if_elig && starved)) begin
            winner_o = REQ_D;
        end
    end

    // Starvation count: grows on data grants that leave a fetch waiting
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fire_o && (winner_o == REQ_IF)) begin
            starve_cnt_d = 4'd0;
        end else if (fire_o && (winner_o == REQ_D) && if_req_i) begin
            if (!starved) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end else if (idle_i && !if_req_i) begin
            starve_cnt_d = 4'd0;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the fetch
// and load/store requesters; also produces the core stall.
module mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    arb_state_e        state_q, state_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              fire;
    logic              winner;
    logic              is_idle;

    assign is_idle = (state_q == IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk      (clk),
        .reset    (reset),
        .idle_i   (is_idle),
        .if_req_i (if_req),
        .halt_i   (halt),
        .d_req_i  (d_req),
        .fire_o   (fire),
        .winner_o (winner)
    );

    // Next state, latency countdown, request latches and memory strobes
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        win_d       = win_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = '0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d  = ACCESS;
                    win_d    = winner;
                    mem_en_d = 1'b1;
                    if (winner == REQ_D) begin
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        we_d       = 1'b0;
                        mem_addr_d = if_addr;
                    end
                end
            end
            ACCESS: begin
                lat_cnt_d = 4'(MEM_LATENCY);
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (win_q == REQ_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 4'd0;
            win_q       <= REQ_IF;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            win_q       <= win_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Handshake pulses and stall decoded from the current state
    always_comb begin
        if_gnt   = (state_q == ACCESS) && (win_q == REQ_IF);
        d_gnt    = (state_q == ACCESS) && (win_q == REQ_D);
        if_valid = (state_q == DONE) && (win_q == REQ_IF);
        d_valid  = (state_q == DONE) && (win_q == REQ_D);
        stall    = (state_q == ACCESS) || (state_q == WAIT) || fire;
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance A (latency 1, starve limit 2)
// covers most scenarios, instance B (latency 4) covers long latency.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A signals
    logic        halt, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    // Instance B signals
    logic        b_req;
    logic [31:0] b_addr, b_mem_rdata;
    logic        b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we, b_stall;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;

    logic [31:0] memA [logic [31:0]];
    logic [31:0] memB [logic [31:0]];
    logic [31:0] pipeA;
    logic [31:0] pipeB [4];

    logic [31:0] ifQ[$];
    logic [31:0] dQ[$];
    logic [31:0] bQ[$];
    logic [31:0] lastD;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)
    ) dut_a (
        .clk(clk), .reset(reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4), .STARVE_LIMIT(4)
    ) dut_b (
        .clk(clk), .reset(reset), .halt(1'b0),
        .if_req(1'b0), .if_addr(32'h0), .if_gnt(b_if_gnt),
        .if_valid(b_if_valid), .if_rdata(b_if_rdata),
        .d_req(b_req), .d_we(1'b0), .d_addr(b_addr), .d_wdata(32'h0),
        .d_gnt(b_d_gnt), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .stall(b_stall)
    );

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Memory A: single-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memA[mem_addr] = mem_wdata;
            else pipeA <= memA.exists(mem_addr) ? memA[mem_addr] : 32'h0;
        end
    end
    assign mem_rdata = pipeA;

    // Memory B: four-cycle read latency
    always @(posedge clk) begin
        pipeB[0] <= (b_mem_en && !b_mem_we && memB.exists(b_mem_addr)) ? memB[b_mem_addr] : 32'h0;
        for (int i = 1; i < 4; i++) pipeB[i] <= pipeB[i-1];
    end
    assign b_mem_rdata = pipeB[3];

    // Scoreboard: every valid pulse pops and compares the oldest expectation
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset) begin
            if (if_valid) begin
                total++;
                if (ifQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_if: unexpected if_valid rdata=%h, required no valid", if_rdata);
                end else begin
                    e = ifQ.pop_front();
                    if (if_rdata !== e) begin
                        bad++;
                        $display("[TB] FAIL sb_if: if_rdata=%h required=%h", if_rdata, e);
                    end
                end
            end
            if (d_valid) begin
                total++;
                if (dQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_d: unexpected d_valid rdata=%h, required no valid", d_rdata);
                end else begin
                    e = dQ.pop_front();
                    if (d_rdata !== e) begin
                        bad++;
                        $display("[TB] FAIL sb_d: d_rdata=%h required=%h", d_rdata, e);
                    end
                end
            end
            if (b_d_valid) begin
                total++;
                if (bQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_b: unexpected d_valid rdata=%h, required no valid", b_d_rdata);
                end else begin
                    e = bQ.pop_front();
                    if (b_d_rdata !== e) begin
                        bad++;
                        $display("[TB] FAIL sb_b: d_rdata=%h required=%h", b_d_rdata, e);
                    end
                end
            end
        end
    end

    function automatic logic sigSel(input int s);
        case (s)
            0: return if_gnt;
            1: return if_valid;
            2: return d_gnt;
            3: return d_valid;
            4: return if_gnt | d_gnt;
            5: return b_d_gnt;
            6: return b_d_valid;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait on a DUT pulse; atCyc = -1 when it never arrives
    task automatic waitEvent(input int sel, output int atCyc);
        atCyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sigSel(sel)) begin
                atCyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall} !== 7'b0 ||
            if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_a: flags=%b if_rdata=%h d_rdata=%h addr=%h, required all 0",
                     {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, stall}, if_rdata, d_rdata, mem_addr);
        end
        total++;
        if ({b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we, b_stall} !== 7'b0 ||
            b_d_rdata !== 32'h0 || b_mem_addr !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_b: flags=%b d_rdata=%h addr=%h, required all 0",
                     {b_if_gnt, b_if_valid, b_d_gnt, b_d_valid, b_mem_en, b_mem_we, b_stall}, b_d_rdata, b_mem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        int t0, at;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        ifQ.push_back(32'hE3A01005);
        t0 = cyc;
        waitEvent(0, at);
        total++;
        if (at != t0 + 1 || mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fetch_gnt: cyc=%0d en=%b we=%b addr=%h stall=%b, required cyc=%0d en=1 we=0 addr=10 stall=1",
                     at, mem_en, mem_we, mem_addr, stall, t0 + 1);
        end
        if_req = 1'b0;
        waitEvent(1, at);
        total++;
        if (at != t0 + 3 || stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fetch_valid: cyc=%0d stall=%b, required cyc=%0d stall=0", at, stall, t0 + 3);
        end
    endtask

    task automatic test_store();
        int t0, weCnt, vAt;
        logic [31:0] wd, wa;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
        dQ.push_back(lastD);
        t0 = cyc; weCnt = 0; vAt = -1; wd = 32'h0; wa = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_we) begin weCnt++; wd = mem_wdata; wa = mem_addr; end
            if (d_gnt) begin d_req = 1'b0; d_we = 1'b0; end
            if (d_valid && vAt < 0) vAt = cyc;
        end
        total++;
        if (weCnt != 1 || wd !== 32'hDEADBEEF || wa !== 32'h200) begin
            bad++;
            $display("[TB] FAIL store_we: we_cycles=%0d wdata=%h addr=%h, required 1 DEADBEEF 200", weCnt, wd, wa);
        end
        total++;
        if (vAt != t0 + 3) begin
            bad++;
            $display("[TB] FAIL store_valid: cyc=%0d required=%0d", vAt, t0 + 3);
        end
    endtask

    task automatic test_arbitration();
        int at, firstAt;
        logic gotData, expData;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        waitEvent(4, firstAt);
        total++;
        if (firstAt < 0 || d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL arb_first: d_gnt=%b if_gnt=%b cyc=%0d, required d_gnt=1 if_gnt=0", d_gnt, if_gnt, firstAt);
        end
        dQ.push_back(32'hDEADBEEF); lastD = 32'hDEADBEEF;
        d_req = 1'b0;
        waitEvent(0, at);
        total++;
        if (at != firstAt + 4) begin
            bad++;
            $display("[TB] FAIL arb_second: fetch gnt cyc=%0d required=%0d", at, firstAt + 4);
        end
        ifQ.push_back(32'hA0A00020);
        if_req = 1'b0;
        waitEvent(1, at);

        // Both held: two data grants, then the starved fetch must win
        if_req = 1'b1; if_addr = 32'h24;
        d_req = 1'b1; d_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            expData = (k < 2);
            waitEvent(4, at);
            gotData = d_gnt;
            total++;
            if (at < 0 || gotData !== expData) begin
                bad++;
                $display("[TB] FAIL starve_%0d: data_won=%b cyc=%0d, required data_won=%b", k, gotData, at, expData);
            end
            if (d_gnt) begin dQ.push_back(32'h12345678); lastD = 32'h12345678; end
            if (if_gnt) begin ifQ.push_back(32'hA0A00024); if_req = 1'b0; d_req = 1'b0; end
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 40 && (ifQ.size() != 0 || dQ.size() != 0); i++) @(negedge clk);
        total++;
        if (ifQ.size() != 0 || dQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL arb_drain: pending if=%0d d=%0d, required 0 0", ifQ.size(), dQ.size());
        end
    endtask

    task automatic test_halt();
        int t0, at;
        logic gotGnt, stallHi;
        @(negedge clk);
        halt = 1'b1; if_req = 1'b1; if_addr = 32'h30;
        gotGnt = 1'b0; stallHi = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if_gnt) gotGnt = 1'b1;
            if (stall) stallHi = 1'b1;
        end
        total++;
        if (gotGnt !== 1'b0 || stallHi !== 1'b0) begin
            bad++;
            $display("[TB] FAIL halt_block: if_gnt_seen=%b stall_seen=%b, required 0 0", gotGnt, stallHi);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        dQ.push_back(32'h12345678); lastD = 32'h12345678;
        t0 = cyc;
        waitEvent(2, at);
        total++;
        if (at != t0 + 1) begin
            bad++;
            $display("[TB] FAIL halt_dgnt: cyc=%0d required=%0d", at, t0 + 1);
        end
        d_req = 1'b0;
        waitEvent(3, at);
        total++;
        if (at != t0 + 3) begin
            bad++;
            $display("[TB] FAIL halt_dvalid: cyc=%0d required=%0d", at, t0 + 3);
        end
        if_req = 1'b0;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic test_reset_midflight();
        int t0, at;
        logic seen;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        dQ.push_back(32'hCAFE0080);
        waitEvent(2, at);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({d_valid, d_gnt, if_valid, mem_en, mem_we, stall} !== 6'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid: flags=%b d_rdata=%h if_rdata=%h, required all 0",
                     {d_valid, d_gnt, if_valid, mem_en, mem_we, stall}, d_rdata, if_rdata);
        end
        ifQ.delete(); dQ.delete(); lastD = 32'h0;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (d_valid) seen = 1'b1; end
        reset = 1'b0;
        repeat (4) begin @(negedge clk); if (d_valid || if_valid) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_abandon: valid_seen=%b required 0", seen);
        end
        if_req = 1'b1; if_addr = 32'h10;
        ifQ.push_back(32'hE3A01005);
        t0 = cyc;
        waitEvent(0, at);
        if_req = 1'b0;
        waitEvent(1, at);
        total++;
        if (at != t0 + 3) begin
            bad++;
            $display("[TB] FAIL reset_refetch: cyc=%0d required=%0d", at, t0 + 3);
        end
    endtask

    task automatic test_long_latency();
        int t0, at;
        @(negedge clk);
        b_req = 1'b1; b_addr = 32'h80;
        bQ.push_back(32'hCAFE0080);
        t0 = cyc;
        waitEvent(5, at);
        total++;
        if (at != t0 + 1 || b_mem_en !== 1'b1 || b_mem_addr !== 32'h80) begin
            bad++;
            $display("[TB] FAIL lat4_gnt: cyc=%0d en=%b addr=%h, required cyc=%0d en=1 addr=80",
                     at, b_mem_en, b_mem_addr, t0 + 1);
        end
        b_req = 1'b0;
        waitEvent(6, at);
        total++;
        if (at != t0 + 6 || b_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lat4_valid: cyc=%0d stall=%b, required cyc=%0d stall=0", at, b_stall, t0 + 6);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ifQ.size() != 0 || dQ.size() != 0 || bQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL final_drain: pending if=%0d d=%0d b=%0d, required 0", ifQ.size(), dQ.size(), bQ.size());
        end
    endtask

    // Main sequence
    initial begin
        reset = 1'b1;
        halt = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        b_req = 1'b0; b_addr = 32'h0;
        lastD = 32'h0;
        memA[32'h10] = 32'hE3A01005;
        memA[32'h20] = 32'hA0A00020;
        memA[32'h24] = 32'hA0A00024;
        memA[32'h40] = 32'h12345678;
        memA[32'h80] = 32'hCAFE0080;
        memB[32'h80] = 32'hCAFE0080;

        test_reset();
        test_fetch_only();
        test_store();
        test_arbitration();
        test_halt();
        test_reset_midflight();
        test_long_latency();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter
